cam_cmd_sequencer: RTL
======================

Name: cam_cmd_sequencer

Overview:
- Command front-end sitting directly upstream of the 32x32 CAM.
- Accepts read/write/search commands over a valid/ready channel and buffers them in a small FIFO.
- Issues one command at a time to the CAM's enable/index/data ports, captures the CAM outputs, and returns an in-order response over a second valid/ready channel.
- Lets bench and system logic drive the CAM without hand-timing its enables.

Parameters:
- DEPTH, 4, command FIFO entries (power of two, >=2)
- IDX_W, 5, CAM index width (32 entries)
- DATA_W, 32, CAM word width
- STAT_W, 16, statistics counter width (used only with the optional feature)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-low
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  FIFO can accept
- cmd_op_i  in  2  00 READ, 01 WRITE, 10 SEARCH, 11 reserved
- cmd_index_i  in  IDX_W  read/write index
- cmd_data_i  in  DATA_W  write data or search key
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accepted
- rsp_op_o  out  2  op of the completed command
- rsp_hit_o  out  1  read valid / search match / write done
- rsp_index_o  out  IDX_W  read/write index, or matched search index
- rsp_data_o  out  DATA_W  read value; echoed key or write data
- cam_read_enable_o  out  1
- cam_read_index_o  out  IDX_W
- cam_write_enable_o  out  1
- cam_write_index_o  out  IDX_W
- cam_write_data_o  out  DATA_W
- cam_search_enable_o  out  1
- cam_search_data_o  out  DATA_W
- cam_read_valid_i  in  1
- cam_read_value_i  in  DATA_W
- cam_search_valid_i  in  1
- cam_search_index_i  in  IDX_W

Behaviour:
- Reset (rst_i low at a posedge):
  - FIFO emptied; FSM to IDLE.
  - All outputs 0, except cmd_ready_o, which is 1 once out of reset.
  - An in-flight command and any pending response are discarded.
  - Reset overrides all other events in the same cycle.
- Command channel:
  - Handshake is cmd_valid_i & cmd_ready_o at a posedge.
  - cmd_ready_o = !full; a registered flag, with no combinational path from rsp_ready_i.
  - A full FIFO does not accept, even when a pop happens in the same cycle.
- FIFO:
  - Circular buffer with wrap-around pointers and a count of 0..DEPTH.
  - Simultaneous push and pop leaves the count unchanged.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
  - IDLE: if the FIFO is non-empty, pop the head into the command register and go to ISSUE.
  - ISSUE: for exactly one cycle, drive the single enable matching the op, with index/data from the command register. Reserved op drives no enable. Go to CAPTURE.
  - CAPTURE: at the end of the cycle, sample the CAM outputs (valid one cycle after the enable) into the response registers. Go to RESP.
  - RESP: rsp_valid_o=1 with the response fields held stable until rsp_ready_i=1.
    - On handshake with the FIFO non-empty: pop and go directly to ISSUE.
    - On handshake with the FIFO empty: go to IDLE.
- Response fields by op:
  - READ: hit = cam_read_valid_i; index = command index; data = cam_read_value_i.
  - WRITE: hit = 1; index = command index; data = write data.
  - SEARCH: hit = cam_search_valid_i; index = cam_search_index_i when hit, else 0; data = search key.
  - Reserved: hit = 0; index = 0; data = 0; the CAM is untouched.
- Latency and throughput:
  - rsp_valid_o rises 3 cycles after the command handshake edge when the block is idle.
  - Steady-state throughput is 1 command per 3 cycles with rsp_ready_i held high.
- Ordering and enables:
  - Responses come back strictly in command order, with one command outstanding to the CAM.
  - Write-then-read/search to the same entry therefore sees the new value.
  - CAM enables are one-hot and never asserted outside ISSUE.

Optional Feature:
- Macro: CAM_SEQ_STATS_EN.
- Defined:
  - Adds output ports stat_search_hit_o and stat_search_miss_o, each STAT_W wide.
  - Each is a saturating counter (holds at all-ones), incremented in CAPTURE for SEARCH ops by hit/miss.
  - Both clear on reset.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package cam_seq_pkg:
  - IDX_W, DATA_W, CAM_ENTRIES=32.
  - cam_op_e enum (READ/WRITE/SEARCH/RSVD).
  - cam_cmd_t struct (op, index, data).
  - cam_rsp_t struct (op, hit, index, data).
  - seq_state_e enum.
- Sub-module cam_cmd_fifo: parameterised DEPTH FIFO of cam_cmd_t with push/pop/full/empty. The sequencer instantiates it once.

Test Plan:
- Reset with rst_i=0 for 2 cycles mid-RESP -> all outputs 0, cmd_ready_o=1 after release, no stale response appears.
- WRITE idx 5 data 0xDEADBEEF, then READ idx 5 -> responses in order: (WRITE, hit=1, idx 5, 0xDEADBEEF), then (READ, hit=1, idx 5, 0xDEADBEEF); rsp_valid_o 3 cycles after the first handshake.
- WRITE idx 17 data 0x12345678, then SEARCH 0x12345678 -> (SEARCH, hit=1, idx 17); SEARCH 0xCAFEF00D -> (hit=0, idx 0).
- Hold rsp_ready_i=0 and push DEPTH+1 commands -> cmd_ready_o drops after DEPTH+1 accepted (DEPTH in FIFO, 1 in flight); releasing rsp_ready_i drains all in order with no loss.
- Reserved op 2'b11 between two READs -> no CAM enable pulse; response (op=3, hit=0, idx 0, data 0); neighbouring responses unaffected.
- With CAM_SEQ_STATS_EN: 3 hitting and 2 missing SEARCHes -> stat_search_hit_o=3, stat_search_miss_o=2. Forced near saturation -> holds at 0xFFFF.

Source files
------------

// File: rtl/cam_seq_pkg.sv
// rtl/cam_seq_pkg.sv - shared types and constants for the CAM command sequencer
// Purpose: CAM geometry, command/response structs and sequencer state encoding.
// Ports: none (package).
package cam_seq_pkg;

  localparam int CAM_ENTRIES = 32;
  localparam int IDX_W       = $clog2(CAM_ENTRIES);
  localparam int DATA_W      = 32;

  typedef enum logic [1:0] {
    OP_READ   = 2'b00,
    OP_WRITE  = 2'b01,
    OP_SEARCH = 2'b10,
    OP_RSVD   = 2'b11
  } cam_op_e;

  typedef struct packed {
    cam_op_e             op;
    logic [IDX_W-1:0]    index;
    logic [DATA_W-1:0]   data;
  } cam_cmd_t;

  typedef struct packed {
    cam_op_e             op;
    logic                hit;
    logic [IDX_W-1:0]    index;
    logic [DATA_W-1:0]   data;
  } cam_rsp_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_RESP
  } seq_state_e;

endpackage

// File: rtl/cam_cmd_fifo.sv
// rtl/cam_cmd_fifo.sv - circular command FIFO feeding the CAM sequencer
// Purpose: DEPTH-entry buffer of cam_cmd_t with wrap-around pointers and an occupancy count.
// Ports:
//   clk, resetn      clock, synchronous active-low reset
//   push, push_cmd   write request (accepted only while ready) and entry to store
//   pop              read request (ignored while empty)
//   head, empty      oldest entry and empty flag
//   ready            registered not-full flag; a full FIFO refuses even when popping
module cam_cmd_fifo
  import cam_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     resetn,
  input  logic     push,
  input  cam_cmd_t push_cmd,
  input  logic     pop,
  output cam_cmd_t head,
  output logic     empty,
  output logic     ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  cam_cmd_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ready;
  assign do_pop  = pop & (count != '0);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // ready is derived from the next count so it never depends on this cycle's pop.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_cmd;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
      ready <= (count_next != CNT_W'(DEPTH));
    end
  end

endmodule

// File: rtl/cam_cmd_sequencer.sv
// rtl/cam_cmd_sequencer.sv - buffered, in-order command front-end for the 32x32 CAM
// Purpose: accepts READ/WRITE/SEARCH commands, issues one at a time to the CAM,
//   captures the CAM result one cycle after the enable and returns an in-order response.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-low reset
//   cmd_*                        command channel (valid/ready, op/index/data)
//   rsp_*                        response channel (valid/ready, op/hit/index/data)
//   cam_*_o                      one-hot CAM enables with index/data
//   cam_*_i                      CAM results, valid one cycle after the enable
//   stat_search_hit_o/_miss_o    saturating SEARCH counters, only with CAM_SEQ_STATS_EN
module cam_cmd_sequencer #(
  parameter int DEPTH  = 4,
  parameter int IDX_W  = cam_seq_pkg::IDX_W,
  parameter int DATA_W = cam_seq_pkg::DATA_W
`ifdef CAM_SEQ_STATS_EN
  , parameter int STAT_W = 16
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [IDX_W-1:0]  cmd_index_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [1:0]        rsp_op_o,
  output logic              rsp_hit_o,
  output logic [IDX_W-1:0]  rsp_index_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              cam_read_enable_o,
  output logic [IDX_W-1:0]  cam_read_index_o,
  output logic              cam_write_enable_o,
  output logic [IDX_W-1:0]  cam_write_index_o,
  output logic [DATA_W-1:0] cam_write_data_o,
  output logic              cam_search_enable_o,
  output logic [DATA_W-1:0] cam_search_data_o,
  input  logic              cam_read_valid_i,
  input  logic [DATA_W-1:0] cam_read_value_i,
  input  logic              cam_search_valid_i,
  input  logic [IDX_W-1:0]  cam_search_index_i
`ifdef CAM_SEQ_STATS_EN
  , output logic [STAT_W-1:0] stat_search_hit_o
  , output logic [STAT_W-1:0] stat_search_miss_o
`endif
);

  import cam_seq_pkg::*;

  seq_state_e state;
  cam_cmd_t   cmd_q;
  cam_cmd_t   push_cmd;
  cam_cmd_t   head;
  cam_rsp_t   rsp_q;
  cam_rsp_t   rsp_next;
  logic       empty;
  logic       pop;

  assign push_cmd = '{op: cam_op_e'(cmd_op_i), index: cmd_index_i, data: cmd_data_i};

  // A new command is loaded either from IDLE or straight out of a completed response.
  assign pop = !empty && ((state == S_IDLE) || ((state == S_RESP) && rsp_ready_i));

  cam_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk_i),
    .resetn   (rst_i),
    .push     (cmd_valid_i),
    .push_cmd (push_cmd),
    .pop      (pop),
    .head     (head),
    .empty    (empty),
    .ready    (cmd_ready_o)
  );

  always_comb begin
    rsp_next    = '0;
    rsp_next.op = cmd_q.op;
    case (cmd_q.op)
      OP_READ: begin
        rsp_next.hit   = cam_read_valid_i;
        rsp_next.index = cmd_q.index;
        rsp_next.data  = cam_read_value_i;
      end
      OP_WRITE: begin
        rsp_next.hit   = 1'b1;
        rsp_next.index = cmd_q.index;
        rsp_next.data  = cmd_q.data;
      end
      OP_SEARCH: begin
        rsp_next.hit   = cam_search_valid_i;
        rsp_next.index = cam_search_valid_i ? cam_search_index_i : '0;
        rsp_next.data  = cmd_q.data;
      end
      default: begin
        rsp_next.hit = 1'b0;
      end
    endcase
  end

  assign rsp_op_o    = rsp_q.op;
  assign rsp_hit_o   = rsp_q.hit;
  assign rsp_index_o = rsp_q.index;
  assign rsp_data_o  = rsp_q.data;

  // Enables are registered on the pop, so they are high exactly for the ISSUE cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state               <= S_IDLE;
      cmd_q               <= '0;
      rsp_q               <= '0;
      rsp_valid_o         <= 1'b0;
      cam_read_enable_o   <= 1'b0;
      cam_read_index_o    <= '0;
      cam_write_enable_o  <= 1'b0;
      cam_write_index_o   <= '0;
      cam_write_data_o    <= '0;
      cam_search_enable_o <= 1'b0;
      cam_search_data_o   <= '0;
    end else begin
      cam_read_enable_o   <= 1'b0;
      cam_write_enable_o  <= 1'b0;
      cam_search_enable_o <= 1'b0;
      case (state)
        S_ISSUE:   state <= S_CAPTURE;
        S_CAPTURE: begin
          rsp_q       <= rsp_next;
          rsp_valid_o <= 1'b1;
          state       <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            if (empty) state <= S_IDLE;
          end
        end
        default: ;
      endcase
      if (pop) begin
        cmd_q               <= head;
        cam_read_enable_o   <= (head.op == OP_READ);
        cam_write_enable_o  <= (head.op == OP_WRITE);
        cam_search_enable_o <= (head.op == OP_SEARCH);
        cam_read_index_o    <= head.index;
        cam_write_index_o   <= head.index;
        cam_write_data_o    <= head.data;
        cam_search_data_o   <= head.data;
        state               <= S_ISSUE;
      end
    end
  end

`ifdef CAM_SEQ_STATS_EN
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stat_search_hit_o  <= '0;
      stat_search_miss_o <= '0;
    end else if ((state == S_CAPTURE) && (cmd_q.op == OP_SEARCH)) begin
      if (cam_search_valid_i) begin
        if (!(&stat_search_hit_o)) stat_search_hit_o <= stat_search_hit_o + 1'b1;
      end else begin
        if (!(&stat_search_miss_o)) stat_search_miss_o <= stat_search_miss_o + 1'b1;
      end
    end
  end
`endif

endmodule
